// File: rtl/dual_stream_frame_checker_pkg.sv
// Shared constants for the dual-stream frame checker: FSM encoding and
// the bit positions inside err_flags.
package dsfc_pkg;

   // FSM encoding, kept as plain vectors so older tools can read the state bus
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACTIVE = 2'd1;
   localparam state_t ST_CHECK  = 2'd2;

   // err_flags = {short_frame, line_len_err, data_err, stray_valid}
   localparam int ERR_STRAY = 0;
   localparam int ERR_DATA  = 1;
   localparam int ERR_LINE  = 2;
   localparam int ERR_SHORT = 3;

endpackage

// File: rtl/dual_stream_frame_checker_if.sv
// Merged image stream coming out of the dual FIFO: frame pulse, line level,
// pixel qualifier and two byte lanes.
interface dual_stream_frame_checker_if #(
   parameter int DWIDTH = 8
) ();
   logic                  image_vs;
   logic                  image_hs;
   logic                  image_valid;
   logic [2*DWIDTH-1:0]   image_data;

   modport master (output image_vs, image_hs, image_valid, image_data);
   modport slave  (input  image_vs, image_hs, image_valid, image_data);
endinterface

// File: rtl/dual_stream_frame_checker_line_meter.sv
// Per-line measurement: hs falling-edge detect, pixel counter, two-lane
// pattern compare against the pixel index, and the line-length check.
// All outputs are combinational and gated by en (frame active).
module line_meter #(
   parameter int FRAME_WIDTH = 1920,
   parameter int CWIDTH      = 12,
   parameter int DWIDTH      = 8
) (
   input  logic                pixclk,
   input  logic                rst,
   input  logic                en,
   input  logic                hs,
   input  logic                valid,
   input  logic [2*DWIDTH-1:0] data,
   output logic                line_end,
   output logic                len_bad,
   output logic                pix_bad,
   output logic                stray
);

   logic              hs_d;
   logic [CWIDTH-1:0] px_cnt;
   logic [DWIDTH-1:0] exp_px;

   assign exp_px = px_cnt[DWIDTH-1:0];

   // Event decode; a pixel on the hs falling-edge cycle is not counted since hs is low
   always_comb begin
      line_end = en && hs_d && !hs;
      len_bad  = line_end && (px_cnt != CWIDTH'(FRAME_WIDTH));
      pix_bad  = en && hs && valid &&
                 ((data[DWIDTH-1:0] != exp_px) || (data[2*DWIDTH-1:DWIDTH] != exp_px));
      stray    = en && valid && !hs;
   end

   // Delayed hs for edge detection, tracked in every state
   always_ff @(posedge pixclk) begin
      if (rst) hs_d <= 1'b0;
      else     hs_d <= hs;
   end

   // Pixel index within the line; held at zero outside an active frame
   always_ff @(posedge pixclk) begin
      if (rst || !en || line_end)
         px_cnt <= '0;
      else if (hs && valid && (px_cnt != '1))
         px_cnt <= px_cnt + CWIDTH'(1);
   end

endmodule

// File: rtl/dual_stream_frame_checker.sv
// Frame checker for the merged dual-stream output: tracks framing with a
// three-state FSM, accumulates per-frame error flags and mismatch count, and
// publishes a registered verdict one cycle after the frame terminates.
module dual_stream_frame_checker
   import dsfc_pkg::*;
#(
   parameter int FRAME_WIDTH  = 1920,
   parameter int FRAME_HEIGHT = 1080,
   parameter int CWIDTH       = 12,
   parameter int DWIDTH       = 8,
   parameter int ECWIDTH      = 16
) (
   input  logic                        pixclk,
   input  logic                        rst,
   dual_stream_frame_checker_if.slave  img,
   output logic                        frame_done,
   output logic                        frame_ok,
   output logic [3:0]                  err_flags,
   output logic [ECWIDTH-1:0]          mismatch_cnt,
   output logic [ECWIDTH-1:0]          frame_cnt
);

   state_t             state;
   logic [CWIDTH-1:0]  line_cnt;
   logic [3:0]         wflags, wflags_nxt;
   logic [ECWIDTH-1:0] wmm, wmm_nxt;
   logic               restart_pend;
   logic               line_end, len_bad, pix_bad, stray;
   logic               last_line, frame_end, start;

   line_meter #(
      .FRAME_WIDTH (FRAME_WIDTH),
      .CWIDTH      (CWIDTH),
      .DWIDTH      (DWIDTH)
   ) u_line_meter (
      .pixclk   (pixclk),
      .rst      (rst),
      .en       (state == ST_ACTIVE),
      .hs       (img.image_hs),
      .valid    (img.image_valid),
      .data     (img.image_data),
      .line_end (line_end),
      .len_bad  (len_bad),
      .pix_bad  (pix_bad),
      .stray    (stray)
   );

   // Next working flags/count, frame-termination and frame-start decode
   always_comb begin
      wflags_nxt = wflags;
      wmm_nxt    = wmm;
      if (pix_bad) begin
         wflags_nxt[ERR_DATA] = 1'b1;
         if (wmm != '1) wmm_nxt = wmm + ECWIDTH'(1);
      end
      if (stray)   wflags_nxt[ERR_STRAY] = 1'b1;
      if (len_bad) wflags_nxt[ERR_LINE]  = 1'b1;
      if (state == ST_ACTIVE && img.image_vs) wflags_nxt[ERR_SHORT] = 1'b1;
      last_line = line_end && (line_cnt == CWIDTH'(FRAME_HEIGHT - 1));
      frame_end = (state == ST_ACTIVE) && (img.image_vs || last_line);
      start     = ((state == ST_IDLE) && img.image_vs) ||
                  ((state == ST_CHECK) && (restart_pend || img.image_vs));
   end

   // FSM and working state; a new frame always starts from cleared state
   always_ff @(posedge pixclk) begin
      if (rst) begin
         state        <= ST_IDLE;
         line_cnt     <= '0;
         wflags       <= '0;
         wmm          <= '0;
         restart_pend <= 1'b0;
      end else if (start) begin
         state        <= ST_ACTIVE;
         line_cnt     <= '0;
         wflags       <= '0;
         wmm          <= '0;
         restart_pend <= 1'b0;
      end else begin
         case (state)
            ST_ACTIVE: begin
               wflags <= wflags_nxt;
               wmm    <= wmm_nxt;
               if (line_end) line_cnt <= line_cnt + CWIDTH'(1);
               if (frame_end) begin
                  state        <= ST_CHECK;
                  restart_pend <= img.image_vs;
               end
            end
            ST_CHECK: state <= ST_IDLE;
            ST_IDLE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Result registers, loaded on the edge that enters CHECK so frame_done is high during CHECK
   always_ff @(posedge pixclk) begin
      if (rst) begin
         frame_done   <= 1'b0;
         frame_ok     <= 1'b0;
         err_flags    <= '0;
         mismatch_cnt <= '0;
         frame_cnt    <= '0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            frame_ok     <= (wflags_nxt == 4'b0000);
            err_flags    <= wflags_nxt;
            mismatch_cnt <= wmm_nxt;
            frame_cnt    <= frame_cnt + ECWIDTH'(1);
         end
      end
   end

endmodule
